// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices, forward-select codes, default widths.
package pipe_hazard_ctrl_pkg;

  localparam int STG_EXE      = 0;
  localparam int STG_MEM      = 1;
  localparam int DEF_STAGES   = 3;
  localparam int DEF_REG_BITS = 4;
  localparam int DEF_CNT_BITS = 16;
  localparam int FWD_REGFILE  = 0;

  // Forward-select code for a producer sitting in tracked stage k.
  function automatic int fwd_code(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_stage_track.sv
// One tracked pipeline entry (valid/dest/wb_en/mem_read); loads every cycle unless held.
module pipe_stage_track #(
  parameter int REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold_i,
  input  logic                valid_i,
  input  logic [REG_BITS-1:0] dest_i,
  input  logic                wb_en_i,
  input  logic                mem_read_i,
  output logic                valid_o,
  output logic [REG_BITS-1:0] dest_o,
  output logic                wb_en_o,
  output logic                mem_read_o
);

  logic                valid_q, wb_en_q, mem_read_q;
  logic [REG_BITS-1:0] dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
    end else if (!hold_i) begin
      valid_q    <= valid_i;
      dest_q     <= dest_i;
      wb_en_q    <= wb_en_i;
      mem_read_q <= mem_read_i;
    end
  end

  assign valid_o    = valid_q;
  assign dest_o     = dest_q;
  assign wb_en_o    = wb_en_q;
  assign mem_read_o = mem_read_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control beside ID: tracks in-flight instructions, derives freeze/bubble/flush and forward selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int  STAGES   = DEF_STAGES,
  parameter int  REG_BITS = DEF_REG_BITS,
  parameter bit  FWD_EN   = 1'b0,
  parameter int  CNT_BITS = DEF_CNT_BITS,
  localparam int FSEL_BITS = $clog2(STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_BITS-1:0]  id_src1,
  input  logic                 id_src1_en,
  input  logic [REG_BITS-1:0]  id_src2,
  input  logic                 id_two_src,
  input  logic [REG_BITS-1:0]  id_dest,
  input  logic                 id_wb_en,
  input  logic                 id_mem_read,
  input  logic                 br_taken,
  input  logic                 mem_stall,
  output logic                 pc_freeze,
  output logic                 idex_bubble,
  output logic                 flush,
  output logic [FSEL_BITS-1:0] fwd_sel1,
  output logic [FSEL_BITS-1:0] fwd_sel2,
  output logic [STAGES-1:0]    stage_valid,
  output logic [CNT_BITS-1:0]  stall_cycles
);

  logic [STAGES-1:0]   valid_q, wb_en_q, mem_read_q;
  logic [REG_BITS-1:0] dest_q [STAGES];
  logic [STAGES-1:0]   m1, m2;
  logic                raw_haz, lu_haz, hazard, ld0;
  logic [FSEL_BITS-1:0] pick1, pick2;
  logic [CNT_BITS-1:0] stall_q, stall_d;
  logic                unused_mem_read;

  // A bubble entering EXE carries no fields, so later stages never see stale producers.
  assign ld0 = id_valid & ~idex_bubble;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STG_EXE) begin : g_head
      pipe_stage_track #(.REG_BITS(REG_BITS)) u_trk (
        .clk(clk), .rst(rst), .hold_i(mem_stall),
        .valid_i(ld0), .dest_i(ld0 ? id_dest : '0),
        .wb_en_i(ld0 & id_wb_en), .mem_read_i(ld0 & id_mem_read),
        .valid_o(valid_q[k]), .dest_o(dest_q[k]),
        .wb_en_o(wb_en_q[k]), .mem_read_o(mem_read_q[k])
      );
    end else begin : g_tail
      pipe_stage_track #(.REG_BITS(REG_BITS)) u_trk (
        .clk(clk), .rst(rst), .hold_i(mem_stall),
        .valid_i(valid_q[k-1]), .dest_i(dest_q[k-1]),
        .wb_en_i(wb_en_q[k-1]), .mem_read_i(mem_read_q[k-1]),
        .valid_o(valid_q[k]), .dest_o(dest_q[k]),
        .wb_en_o(wb_en_q[k]), .mem_read_o(mem_read_q[k])
      );
    end
  end

  assign unused_mem_read = ^mem_read_q;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < STAGES; k++) begin
      m1[k] = valid_q[k] & wb_en_q[k] & id_src1_en & (dest_q[k] == id_src1);
      m2[k] = valid_q[k] & wb_en_q[k] & id_two_src & (dest_q[k] == id_src2);
    end
  end

  // WB is excluded from the stall check because the regfile writes before it is read.
  assign raw_haz = |(m1[STAGES-2:0] | m2[STAGES-2:0]);
  assign lu_haz  = (m1[STG_EXE] | m2[STG_EXE]) & mem_read_q[STG_EXE];
  assign hazard  = id_valid & (FWD_EN ? lu_haz : raw_haz);

  // Scan oldest to youngest so the youngest matching producer overwrites.
  always_comb begin
    pick1 = FSEL_BITS'(FWD_REGFILE);
    pick2 = FSEL_BITS'(FWD_REGFILE);
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (m1[k]) pick1 = FSEL_BITS'(fwd_code(k));
      if (m2[k]) pick2 = FSEL_BITS'(fwd_code(k));
    end
  end

  assign fwd_sel1    = FWD_EN ? pick1 : FSEL_BITS'(FWD_REGFILE);
  assign fwd_sel2    = FWD_EN ? pick2 : FSEL_BITS'(FWD_REGFILE);
  assign flush       = br_taken & ~mem_stall;
  assign pc_freeze   = mem_stall | (hazard & ~br_taken);
  assign idex_bubble = ~mem_stall & (hazard | flush);
  assign stage_valid = valid_q;

  assign stall_d = (pc_freeze && !(&stall_q)) ? stall_q + CNT_BITS'(1) : stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: stall-mode, forwarding-mode and narrow-counter instances share one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_src1_en, id_two_src, id_wb_en, id_mem_read, br_taken, mem_stall;
  logic [3:0] id_src1, id_src2, id_dest;

  logic        a_frz, a_bub, a_fl, b_frz, b_bub, b_fl, c_frz, c_bub, c_fl;
  logic [1:0]  a_f1, a_f2, b_f1, b_f2, c_f1, c_f2;
  logic [2:0]  a_sv, b_sv, c_sv;
  logic [15:0] a_cnt, b_cnt;
  logic [3:0]  c_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1'b0)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .br_taken(br_taken), .mem_stall(mem_stall),
    .pc_freeze(a_frz), .idex_bubble(a_bub), .flush(a_fl), .fwd_sel1(a_f1), .fwd_sel2(a_f2),
    .stage_valid(a_sv), .stall_cycles(a_cnt));

  pipe_hazard_ctrl #(.FWD_EN(1'b1)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .br_taken(br_taken), .mem_stall(mem_stall),
    .pc_freeze(b_frz), .idex_bubble(b_bub), .flush(b_fl), .fwd_sel1(b_f1), .fwd_sel2(b_f2),
    .stage_valid(b_sv), .stall_cycles(b_cnt));

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .CNT_BITS(4)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .br_taken(br_taken), .mem_stall(mem_stall),
    .pc_freeze(c_frz), .idex_bubble(c_bub), .flush(c_fl), .fwd_sel1(c_f1), .fwd_sel2(c_f2),
    .stage_valid(c_sv), .stall_cycles(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic s1en, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb, input logic mr);
    id_valid = v;  id_src1 = s1; id_src1_en = s1en; id_src2 = s2;
    id_two_src = two; id_dest = d; id_wb_en = wb; id_mem_read = mr;
    #1;
  endtask

  task automatic do_reset();
    br_taken = 1'b0;
    mem_stall = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    br_taken = 1'b0;
    mem_stall = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    n_checks++;
    if ({a_frz, a_bub, a_fl, a_f1, a_f2, a_sv} !== 10'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0", {a_frz, a_bub, a_fl, a_f1, a_f2, a_sv});
    end
    n_checks++;
    if (a_cnt !== 16'd0 || b_cnt !== 16'd0 || c_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d required 0", a_cnt, b_cnt, c_cnt);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({b_frz, b_bub, b_fl, b_f1, b_f2, b_sv, b_cnt} !== 26'd0) begin
      n_fail++; $display("FAIL post_reset: got %h required 0", {b_frz, b_bub, b_fl, b_f1, b_f2, b_sv, b_cnt});
    end
  endtask

  // ADD R3,R1,R2 then SUB R4,R3,R1 in stall-only mode.
  task automatic test_raw_stall();
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    n_checks++;
    if (a_frz !== 1'b0) begin n_fail++; $display("FAIL raw_first_nofreeze: got %b required 0", a_frz); end
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({a_frz, a_bub, a_f1} !== 4'b1100) begin
        n_fail++; $display("FAIL raw_stall_c%0d: got frz/bub/sel %b required 1100", i, {a_frz, a_bub, a_f1});
      end
      tick();
    end
    n_checks++;
    if ({a_frz, a_bub} !== 2'b00) begin
      n_fail++; $display("FAIL raw_release: got %b required 00", {a_frz, a_bub});
    end
    n_checks++;
    if (a_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_cnt: got %0d required 2", a_cnt); end
  endtask

  // Forwarding mode: consumer source stays R3 while the producer walks EXE -> MEM -> WB.
  task automatic test_forward();
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b0, 1'b0);
    n_checks++;
    if ({b_frz, b_bub, b_f1, b_f2} !== 6'b00_01_00) begin
      n_fail++; $display("FAIL fwd_exe: got frz/bub/s1/s2 %b required 000100", {b_frz, b_bub, b_f1, b_f2});
    end
    tick();
    n_checks++;
    if (b_f1 !== 2'd2) begin n_fail++; $display("FAIL fwd_mem: got %0d required 2", b_f1); end
    tick();
    n_checks++;
    if (b_f1 !== 2'd3) begin n_fail++; $display("FAIL fwd_wb: got %0d required 3", b_f1); end
    tick();
    n_checks++;
    if (b_f1 !== 2'd0) begin n_fail++; $display("FAIL fwd_retired: got %0d required 0", b_f1); end
  endtask

  // LDR R2 then ADD R5,R2,R2: one load-use freeze, then both sources from MEM.
  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);
    n_checks++;
    if ({b_frz, b_bub} !== 2'b11) begin
      n_fail++; $display("FAIL lu_freeze: got %b required 11", {b_frz, b_bub});
    end
    tick();
    n_checks++;
    if ({b_frz, b_bub, b_f1, b_f2} !== 6'b00_10_10) begin
      n_fail++; $display("FAIL lu_fwd: got frz/bub/s1/s2 %b required 001010", {b_frz, b_bub, b_f1, b_f2});
    end
    n_checks++;
    if (b_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d required 1", b_cnt); end
  endtask

  task automatic test_flush_priority();
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);
    br_taken = 1'b1;
    #1;
    n_checks++;
    if ({a_fl, a_bub, a_frz} !== 3'b110) begin
      n_fail++; $display("FAIL flush_prio: got fl/bub/frz %b required 110", {a_fl, a_bub, a_frz});
    end
    tick();
    br_taken = 1'b0;
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++;
    if (a_cnt !== 16'd0 || a_sv !== 3'b010) begin
      n_fail++; $display("FAIL flush_after: got cnt %0d sv %b required 0 010", a_cnt, a_sv);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    br_taken = 1'b1;
    mem_stall = 1'b1;
    #1;
    n_checks++;
    if ({a_fl, a_frz, a_bub} !== 3'b010) begin
      n_fail++; $display("FAIL ms_ctrl: got fl/frz/bub %b required 010", {a_fl, a_frz, a_bub});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (a_sv !== 3'b001) begin n_fail++; $display("FAIL ms_hold_c%0d: got %b required 001", i, a_sv); end
    end
    mem_stall = 1'b0;
    #1;
    n_checks++;
    if ({a_fl, a_bub, a_frz} !== 3'b110 || a_cnt !== 16'd3) begin
      n_fail++; $display("FAIL ms_release: got fl/bub/frz %b cnt %0d required 110 3", {a_fl, a_bub, a_frz}, a_cnt);
    end
    tick();
    br_taken = 1'b0;
    #1;
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 4'd4, 1'b1, 1'b0);
    mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (c_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4: got %0d required 15", c_cnt); end
    n_checks++;
    if (a_cnt !== 16'd20 || c_frz !== 1'b1) begin
      n_fail++; $display("FAIL sat_cnt16: got %0d frz %b required 20 1", a_cnt, c_frz);
    end
    #2;
    mem_stall = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({c_frz, c_bub, c_fl, c_f1, c_f2, c_sv, c_cnt} !== 14'd0) begin
      n_fail++; $display("FAIL midrun_rst: got %b required 0", {c_frz, c_bub, c_fl, c_f1, c_f2, c_sv, c_cnt});
    end
    n_checks++;
    if ({a_frz, a_sv, a_cnt} !== 20'd0) begin
      n_fail++; $display("FAIL midrun_rst_a: got %h required 0", {a_frz, a_sv, a_cnt});
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_forward();
    test_load_use();
    test_flush_priority();
    test_mem_stall();
    test_saturate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
